// File: rtl/add8_sched_pkg.sv
// add8_sched_pkg: shared widths, state encoding and response record for the adder scheduler
package add8_sched_pkg;
  localparam int OPW = 8;
  localparam int RESW = 9;
  localparam int MAXIDW = 4;
  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  typedef enum logic {EMPTY, FULL} state_t;
  typedef struct packed {
    logic [RESW-1:0] sum;
    logic [MAXIDW-1:0] id;
  } rsp_t;
endpackage

// File: rtl/add8_rr_sched_if.sv
// add8_rr_sched_if: request and response bundle between the lanes and the shared adder
interface add8_rr_sched_if import add8_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
);
  localparam int IDW = idw(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [RESW-1:0] rsp_sum;
  logic [IDW-1:0] rsp_id;
  logic [CNTW-1:0] ops_cnt;
  logic busy;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input req_ready, rsp_valid, rsp_sum, rsp_id, ops_cnt, busy
  );
  modport slave (
    input req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, ops_cnt, busy
  );
endinterface

// File: rtl/add8_loa_core.sv
// add8_loa_core: lower-part-OR approximate adder, 2 OR'd low bits, exact upper part with carry from a1&b1
module add8_loa_core (
  input logic [7:0] A,
  input logic [7:0] B,
  output logic [8:0] O
);
  logic [6:0] hi;
  assign hi = {1'b0, A[7:2]} + {1'b0, B[7:2]} + {6'd0, A[1] & B[1]};
  assign O = {hi, A[1:0] | B[1:0]};
endmodule

// File: rtl/add8_rr_arb.sv
// add8_rr_arb: rotating-priority arbiter, lowest offset from ptr among set requests wins
module add8_rr_arb import add8_sched_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IDW = idw(NREQ)
) (
  input logic [NREQ-1:0] req,
  input logic [IDW-1:0] ptr,
  input logic en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0] idx,
  output logic any
);
  // scan offsets from the top down so the smallest offset is written last and wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr) + i) % NREQ;
      if (req[j]) begin
        idx = IDW'(j);
        any = 1'b1;
      end
    end
    any = any & en;
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/add8_rr_sched.sv
// add8_rr_sched: round-robin sharing of one approximate adder core with a single registered response slot
module add8_rr_sched import add8_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic rst_n,
  add8_rr_sched_if.slave bus
);
  localparam int IDW = idw(NREQ);
  state_t state, state_nx;
  rsp_t rsp_q;
  logic [IDW-1:0] rr_ptr, idx;
  logic [NREQ-1:0] gnt;
  logic grant, slot_free;
  logic [OPW-1:0] a_sel, b_sel;
  logic [RESW-1:0] core_o;
  logic [CNTW-1:0] cnt;
  // rst_n gates the arbiter so no lane sees ready while reset is held
  assign slot_free = (state == EMPTY) | bus.rsp_ready;
  add8_rr_arb #(.NREQ(NREQ)) u_arb (
    .req(bus.req_valid), .ptr(rr_ptr), .en(slot_free & rst_n),
    .gnt(gnt), .idx(idx), .any(grant)
  );
  assign a_sel = bus.req_a[idx*OPW +: OPW];
  assign b_sel = bus.req_b[idx*OPW +: OPW];
  add8_loa_core u_core (.A(a_sel), .B(b_sel), .O(core_o));
  // a grant always fills the slot; otherwise a taken response empties it
  always_comb begin
    state_nx = grant ? FULL : (bus.rsp_ready ? EMPTY : state);
  end
  // response slot, rotating pointer and saturating handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rsp_q <= '0;
      rr_ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        rsp_q <= '{sum: core_o, id: MAXIDW'(idx)};
        rr_ptr <= (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
      if (state == FULL && bus.rsp_ready && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_sum = rsp_q.sum;
  assign bus.rsp_id = IDW'(rsp_q.id);
  assign bus.ops_cnt = cnt;
  assign bus.busy = (state == FULL) | (|bus.req_valid);
endmodule

// File: tb/tb_add8_rr_sched.sv
// tb_add8_rr_sched: table vectors, directed corner sequences and random stress against a behavioural model
module tb_add8_rr_sched;
  localparam int NREQ = 4;
  localparam int CNTW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  add8_rr_sched_if #(.NREQ(NREQ), .CNTW(CNTW)) bus ();
  add8_rr_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int m_ptr, m_cnt, m_id;
  bit m_full;
  logic [8:0] m_sum;
  int wait_n [NREQ];
  logic [NREQ-1:0] s_ready;
  logic s_vld;
  logic [8:0] s_sum;
  logic [1:0] s_id;
  logic [CNTW-1:0] s_cnt;

  typedef struct {
    int id;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
  } vec_t;

  function automatic logic [8:0] core_model(logic [7:0] a, logic [7:0] b);
    int hi;
    hi = int'(a) / 4 + int'(b) / 4 + ((a[1] && b[1]) ? 1 : 0);
    return 9'(hi * 4 + (int'(a | b) % 4));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_op(int i, logic [7:0] a, logic [7:0] b);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
  endtask

  task automatic step();
    int g;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    if (!rst_n) begin
      m_full = 0; m_cnt = 0; m_ptr = 0; m_sum = '0; m_id = 0;
      foreach (wait_n[i]) wait_n[i] = 0;
    end
    g = -1;
    if (rst_n && (!m_full || bus.rsp_ready))
      for (int k = NREQ - 1; k >= 0; k--)
        if (bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_ready = (g >= 0) ? NREQ'(1) << g : '0;
    s_ready = bus.req_ready; s_vld = bus.rsp_valid; s_sum = bus.rsp_sum;
    s_id = bus.rsp_id; s_cnt = bus.ops_cnt;
    chk("req_ready", s_ready, exp_ready);
    chk("rsp_valid", s_vld, m_full);
    chk("ops_cnt", s_cnt, m_cnt);
    chk("busy", bus.busy, m_full | (|bus.req_valid));
    if (m_full || !rst_n) begin
      chk("rsp_sum", s_sum, m_sum);
      chk("rsp_id", s_id, m_id);
    end
    for (int i = 0; i < NREQ; i++)
      if (s_ready[i]) begin
        chk("fairness", wait_n[i] < NREQ, 1);
        for (int k = 0; k < NREQ; k++) if (k != i && bus.req_valid[k]) wait_n[k]++;
        wait_n[i] = 0;
      end
    if (rst_n) begin
      if (m_full && bus.rsp_ready) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
      if (g >= 0) begin
        m_full = 1;
        m_sum = core_model(bus.req_a[g*8 +: 8], bus.req_b[g*8 +: 8]);
        m_id = g;
        m_ptr = (g + 1) % NREQ;
      end else if (bus.rsp_ready) m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  vec_t tbl [8];
  int hold;

  initial begin
    tbl[0] = '{1, 8'h35, 8'h4A, 9'h07F};
    tbl[1] = '{0, 8'hFF, 8'hFF, 9'h1FF};
    tbl[2] = '{2, 8'h03, 8'h01, 9'h003};
    tbl[3] = '{3, 8'h02, 8'h02, 9'h006};
    tbl[4] = '{1, 8'h80, 8'h80, 9'h100};
    tbl[5] = '{2, 8'h00, 8'h00, 9'h000};
    tbl[6] = '{0, 8'h7F, 8'h01, 9'h07F};
    tbl[7] = '{3, 8'hA5, 8'h5A, 9'h0FF};
    bus.req_valid = '0; bus.rsp_ready = 1'b1;
    bus.req_a = '0; bus.req_b = '0;
    #2 rst_n = 1'b0;
    // T1: reset held with every lane valid
    bus.req_valid = '1;
    step(); step();
    chk("t1_ready_in_reset", s_ready, 0);
    chk("t1_vld_in_reset", s_vld, 0);
    rst_n = 1'b1;
    step();
    chk("t1_first_grant", s_ready, 4'b0001);
    // T2 and table: single ops, random junk on idle lanes
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom), 8'($urandom));
      set_op(tbl[k].id, tbl[k].a, tbl[k].b);
      bus.req_valid = NREQ'(1) << tbl[k].id;
      step();
      chk("tbl_ready", s_ready, NREQ'(1) << tbl[k].id);
      bus.req_valid = '0;
      step();
      chk("tbl_vld", s_vld, 1);
      chk("tbl_sum", s_sum, tbl[k].sum);
      chk("tbl_id", s_id, tbl[k].id);
    end
    step();
    // T3: all lanes valid, back-to-back round robin from a fresh pointer
    pulse_reset();
    bus.req_valid = '1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t3_grant", s_ready, NREQ'(1) << (k % 4));
      if (k > 0) begin
        chk("t3_vld", s_vld, 1);
        chk("t3_id", s_id, (k - 1) % 4);
      end
    end
    // T4: backpressure holds the slot and blocks grants
    bus.rsp_ready = 1'b0;
    step();
    hold = s_id;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_id_stable", s_id, hold);
      chk("t4_no_ready", s_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("t4_next_grant", s_ready, NREQ'(1) << ((hold + 1) % 4));
    // T5: reset while a response is stalled
    bus.rsp_ready = 1'b0;
    step();
    chk("t5_held", s_vld, 1);
    rst_n = 1'b0;
    #1 chk("t5_async_clear", bus.rsp_valid, 0);
    bus.req_valid = '0;
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_never_delivered", s_vld, 0);
    end
    // T6: counter saturation after 21 handshakes
    pulse_reset();
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 22; k++) step();
    chk("t6_saturated", s_cnt, 4'hF);
    // random stress: lanes hold valid and operands until accepted
    bus.req_valid = '0;
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] || s_ready[i]) begin
          bus.req_valid[i] = 1'($urandom);
          set_op(i, 8'($urandom), 8'($urandom));
        end
      bus.rsp_ready = ($urandom_range(3) != 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
